// File: rtl/minialu_pkg.sv
// MiniAlu shared definitions.
// Field layout, storage geometry and opcodes.
package minialu_pkg;

  localparam int INSTR_W    = 28;
  localparam int DATA_W     = 16;
  localparam int DATA_AW    = 8;
  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam int VID_W      = 3;
  localparam int VID_AW     = 24;
  localparam int VID_DEPTH  = 640 * 480;

  localparam int OP_HI   = 27;
  localparam int OP_LO   = 24;
  localparam int DST_HI  = 23;
  localparam int DST_LO  = 16;
  localparam int SRC1_HI = 15;
  localparam int SRC1_LO = 8;
  localparam int SRC0_HI = 7;
  localparam int SRC0_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LED  = 4'h1,
    OP_BLE  = 4'h2,
    OP_STO  = 4'h3,
    OP_ADD  = 4'h4,
    OP_JMP  = 4'h5,
    OP_SUB  = 4'h6,
    OP_SMUL = 4'h7,
    OP_VGA  = 4'h8
  } opcode_e;

  // Packed so that a cast of the raw
  // word lands every slice in place.
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] dst;
    logic [7:0] src1;
    logic [7:0] src0;
  } instr_t;

endpackage

// File: rtl/sync_ram_1w2r.sv
// Synchronous RAM, one write port,
// one or two registered read ports.
module sync_ram_1w2r #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int NRD   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1
);

  localparam int IW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic wr_ok;
  logic rd_ok0;
  logic rd_ok1;

  generate
    if (DEPTH >= (2 ** AW)) begin : g_full
      assign wr_ok  = 1'b1;
      assign rd_ok0 = 1'b1;
      assign rd_ok1 = 1'b1;
    end else begin : g_guard
      assign wr_ok  = waddr  < AW'(DEPTH);
      assign rd_ok0 = raddr0 < AW'(DEPTH);
      assign rd_ok1 = raddr1 < AW'(DEPTH);
    end
  endgenerate

  // Array write; blocked in reset and
  // for addresses past the depth.
  always_ff @(posedge clk) begin
    if (rst_n && we && wr_ok)
      mem[waddr[IW-1:0]] <= wdata;
  end

  // Read port 0, old data on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata0 <= '0;
    else if (rd_ok0)
      rdata0 <= mem[raddr0[IW-1:0]];
    else
      rdata0 <= '0;
  end

  generate
    if (NRD == 2) begin : g_rd1
      // Read port 1, same timing as port 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          rdata1 <= '0;
        else if (rd_ok1)
          rdata1 <= mem[raddr1[IW-1:0]];
        else
          rdata1 <= '0;
      end
    end else begin : g_no_rd1
      logic unused_rd1;
      assign unused_rd1 = ^{raddr1, rd_ok1};
      assign rdata1 = '0;
    end
  endgenerate

endmodule

// File: rtl/minialu_storage_unit.sv
// MiniAlu storage back-end: field
// registers, data RAM, video memory.
module minialu_storage_unit
  import minialu_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iFieldEnable,
  output logic [3:0]         oOperation,
  output logic [7:0]         oSourceAddr0,
  output logic [7:0]         oSourceAddr1,
  output logic [7:0]         oDestination,
  input  logic               iDataWriteEnable,
  input  logic [DATA_AW-1:0] iDataWriteAddress,
  input  logic [DATA_W-1:0]  iDataIn,
  output logic [DATA_W-1:0]  oSourceData0,
  output logic [DATA_W-1:0]  oSourceData1,
  input  logic               iVideoWriteEnable,
  input  logic [VID_AW-1:0]  iVideoWriteAddress,
  input  logic [VID_W-1:0]   iVideoDataIn,
  input  logic [VID_AW-1:0]  iVideoReadAddress,
  output logic [VID_W-1:0]   oVideoData
);

  instr_t instr;
  logic [VID_W-1:0] unused_vid1;

  assign instr = instr_t'(iInstruction);

  // Enabled capture of the decoded fields.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oOperation   <= '0;
      oDestination <= '0;
      oSourceAddr1 <= '0;
      oSourceAddr0 <= '0;
    end else if (iFieldEnable) begin
      oOperation   <= instr.op;
      oDestination <= instr.dst;
      oSourceAddr1 <= instr.src1;
      oSourceAddr0 <= instr.src0;
    end
  end

  // Read addresses use the raw word so
  // data lines up with the field regs.
  sync_ram_1w2r #(
    .W     (DATA_W),
    .DEPTH (DATA_DEPTH),
    .AW    (DATA_AW),
    .NRD   (2)
  ) u_data_ram (
    .clk    (Clock),
    .rst_n  (Reset),
    .we     (iDataWriteEnable),
    .waddr  (iDataWriteAddress),
    .wdata  (iDataIn),
    .raddr0 (instr.src0),
    .raddr1 (instr.src1),
    .rdata0 (oSourceData0),
    .rdata1 (oSourceData1)
  );

  sync_ram_1w2r #(
    .W     (VID_W),
    .DEPTH (VID_DEPTH),
    .AW    (VID_AW),
    .NRD   (1)
  ) u_video_ram (
    .clk    (Clock),
    .rst_n  (Reset),
    .we     (iVideoWriteEnable),
    .waddr  (iVideoWriteAddress),
    .wdata  (iVideoDataIn),
    .raddr0 (iVideoReadAddress),
    .raddr1 ('0),
    .rdata0 (oVideoData),
    .rdata1 (unused_vid1)
  );

endmodule

// File: tb/tb_minialu_storage_unit.sv
// Bench for minialu_storage_unit:
// reference model plus directed vectors.
module tb_minialu_storage_unit;

  localparam int VDEPTH = 307200;

  logic        Clock;
  logic        Reset;
  logic [27:0] iInstruction;
  logic        iFieldEnable;
  logic [3:0]  oOperation;
  logic [7:0]  oSourceAddr0;
  logic [7:0]  oSourceAddr1;
  logic [7:0]  oDestination;
  logic        iDataWriteEnable;
  logic [7:0]  iDataWriteAddress;
  logic [15:0] iDataIn;
  logic [15:0] oSourceData0;
  logic [15:0] oSourceData1;
  logic        iVideoWriteEnable;
  logic [23:0] iVideoWriteAddress;
  logic [2:0]  iVideoDataIn;
  logic [23:0] iVideoReadAddress;
  logic [2:0]  oVideoData;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  minialu_storage_unit dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iInstruction       (iInstruction),
    .iFieldEnable       (iFieldEnable),
    .oOperation         (oOperation),
    .oSourceAddr0       (oSourceAddr0),
    .oSourceAddr1       (oSourceAddr1),
    .oDestination       (oDestination),
    .iDataWriteEnable   (iDataWriteEnable),
    .iDataWriteAddress  (iDataWriteAddress),
    .iDataIn            (iDataIn),
    .oSourceData0       (oSourceData0),
    .oSourceData1       (oSourceData1),
    .iVideoWriteEnable  (iVideoWriteEnable),
    .iVideoWriteAddress (iVideoWriteAddress),
    .iVideoDataIn       (iVideoDataIn),
    .iVideoReadAddress  (iVideoReadAddress),
    .oVideoData         (oVideoData)
  );

  initial Clock = 0;
  always #5 Clock = ~Clock;

  // Reference model state.
  logic [15:0] dm [int];
  logic [2:0]  vm [int];
  logic [3:0]  e_op;
  logic [7:0]  e_s0a, e_s1a, e_dst;
  logic [15:0] e_sd0, e_sd1;
  logic [2:0]  e_vd;
  bit k0, k1, kv;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: outputs on each edge from
  // pre-edge contents, then apply writes.
  always @(posedge Clock) begin
    int a0, a1, ra, wa;
    if (!Reset) begin
      e_op = 0; e_s0a = 0; e_s1a = 0; e_dst = 0;
      e_sd0 = 0; e_sd1 = 0; e_vd = 0;
      k0 = 1; k1 = 1; kv = 1;
    end else begin
      a0 = int'(iInstruction[7:0]);
      a1 = int'(iInstruction[15:8]);
      ra = int'(iVideoReadAddress);
      k0 = dm.exists(a0);
      k1 = dm.exists(a1);
      if (k0) e_sd0 = dm[a0];
      if (k1) e_sd1 = dm[a1];
      if (ra >= VDEPTH) begin
        kv = 1; e_vd = 0;
      end else begin
        kv = vm.exists(ra);
        if (kv) e_vd = vm[ra];
      end
      if (iFieldEnable) begin
        e_op  = iInstruction[27:24];
        e_dst = iInstruction[23:16];
        e_s1a = iInstruction[15:8];
        e_s0a = iInstruction[7:0];
      end
      if (iDataWriteEnable)
        dm[int'(iDataWriteAddress)] = iDataIn;
      wa = int'(iVideoWriteAddress);
      if (iVideoWriteEnable && wa < VDEPTH)
        vm[wa] = iVideoDataIn;
    end
  end

  // Compare DUT against model every cycle.
  always @(negedge Clock) begin
    if (started) begin
      chk("cmp_op", 32'(oOperation), 32'(e_op));
      chk("cmp_dst", 32'(oDestination), 32'(e_dst));
      chk("cmp_s1a", 32'(oSourceAddr1), 32'(e_s1a));
      chk("cmp_s0a", 32'(oSourceAddr0), 32'(e_s0a));
      if (k0) chk("cmp_sd0", 32'(oSourceData0), 32'(e_sd0));
      if (k1) chk("cmp_sd1", 32'(oSourceData1), 32'(e_sd1));
      if (kv) chk("cmp_vd", 32'(oVideoData), 32'(e_vd));
    end
  end

  task automatic step(input logic [27:0] ins,
                      input logic fe,
                      input logic dwe,
                      input logic [7:0] dwa,
                      input logic [15:0] ddi,
                      input logic vwe,
                      input logic [23:0] vwa,
                      input logic [2:0] vdi,
                      input logic [23:0] vra);
    iInstruction       = ins;
    iFieldEnable       = fe;
    iDataWriteEnable   = dwe;
    iDataWriteAddress  = dwa;
    iDataIn            = ddi;
    iVideoWriteEnable  = vwe;
    iVideoWriteAddress = vwa;
    iVideoDataIn       = vdi;
    iVideoReadAddress  = vra;
    @(negedge Clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op"}, 32'(oOperation), 0);
    chk({tag, "_dst"}, 32'(oDestination), 0);
    chk({tag, "_s1a"}, 32'(oSourceAddr1), 0);
    chk({tag, "_s0a"}, 32'(oSourceAddr0), 0);
    chk({tag, "_sd0"}, 32'(oSourceData0), 0);
    chk({tag, "_sd1"}, 32'(oSourceData1), 0);
    chk({tag, "_vd"}, 32'(oVideoData), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1;
    iInstruction = 0; iFieldEnable = 0;
    iDataWriteEnable = 0; iDataWriteAddress = 0;
    iDataIn = 0; iVideoWriteEnable = 0;
    iVideoWriteAddress = 0; iVideoDataIn = 0;
    iVideoReadAddress = 0;
    #1 Reset = 0;
    #1 chk_zero("por");
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1;
    started = 1;

    // preload data RAM
    step(0, 0, 1, 8'h05, 16'h1234, 0, 0, 0, 0);
    step(0, 0, 1, 8'h03, 16'h00FF, 0, 0, 0, 0);
    step(0, 0, 1, 8'h07, 16'hFF00, 0, 0, 0, 0);
    step(0, 0, 1, 8'h09, 16'h0001, 0, 0, 0, 0);

    // field capture and hold
    step(28'h5A3C2B1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("fld_op", 32'(oOperation), 32'h5);
    chk("fld_dst", 32'(oDestination), 32'hA3);
    chk("fld_s1a", 32'(oSourceAddr1), 32'hC2);
    chk("fld_s0a", 32'(oSourceAddr0), 32'hB1);
    step(28'h1234567, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_op", 32'(oOperation), 32'h5);
    chk("hold_dst", 32'(oDestination), 32'hA3);
    chk("hold_s0a", 32'(oSourceAddr0), 32'hB1);

    // dual read, then same address
    step(28'h0000703, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dual_sd1", 32'(oSourceData1), 32'hFF00);
    chk("dual_sd0", 32'(oSourceData0), 32'h00FF);
    chk("model_sd1", 32'(e_sd1), 32'hFF00);
    step(28'h0000303, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("same_sd0", 32'(oSourceData0), 32'h00FF);
    chk("same_sd1", 32'(oSourceData1), 32'h00FF);

    // read during write returns old data
    step(28'h0000909, 0, 1, 8'h09, 16'h0002, 0, 0, 0, 0);
    chk("rdw_old", 32'(oSourceData0), 32'h0001);
    chk("model_rdw", 32'(e_sd0), 32'h0001);
    step(28'h0000909, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rdw_new", 32'(oSourceData0), 32'h0002);
    chk("rdw_new1", 32'(oSourceData1), 32'h0002);

    // video memory and range guard
    step(0, 0, 0, 0, 0, 1, 24'd0, 3'b101, 0);
    step(0, 0, 0, 0, 0, 1, 24'd307199, 3'b010, 0);
    step(0, 0, 0, 0, 0, 1, 24'd307200, 3'b111, 0);
    chk("vid_0", 32'(oVideoData), 32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 24'd307199);
    chk("vid_last", 32'(oVideoData), 32'h2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 24'd307200);
    chk("vid_oor", 32'(oVideoData), 32'h0);
    chk("model_oor", 32'(vm.exists(VDEPTH)), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 24'hFFFFFF);
    chk("vid_max", 32'(oVideoData), 32'h0);

    // concurrent data + video writes
    step(0, 0, 1, 8'h10, 16'hBEEF, 1, 24'd100, 3'b110, 0);
    step(28'h0001000, 0, 0, 0, 0, 0, 0, 0, 24'd100);
    chk("cc_data", 32'(oSourceData1), 32'hBEEF);
    chk("cc_vid", 32'(oVideoData), 32'h6);

    // async reset mid-run, contents survive
    step(28'h1000505, 1, 0, 0, 0, 0, 0, 0, 24'd0);
    chk("pre_rst_sd0", 32'(oSourceData0), 32'h1234);
    chk("pre_rst_op", 32'(oOperation), 32'h1);
    chk("pre_rst_vd", 32'(oVideoData), 32'h5);
    #2 Reset = 0;
    #1 chk_zero("arst");
    step(28'h0000303, 1, 1, 8'h05, 16'hDEAD,
         1, 24'd0, 3'b011, 0);
    chk_zero("inrst");
    Reset = 1;
    step(28'h0000505, 1, 0, 0, 0, 0, 0, 0, 24'd0);
    chk("post_sd0", 32'(oSourceData0), 32'h1234);
    chk("post_vd", 32'(oVideoData), 32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    started = 0;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/minialu_storage_unit.md
Name: minialu_storage_unit

Overview:
- Storage back-end of the MiniAlu core, in one block:
  - the instruction-field pipeline register bank (opcode, two source addresses, destination);
  - the 256x16 dual-read data register RAM;
  - the 3-bit-per-pixel 640x480 video frame memory.
- It sits between the instruction ROM / ALU decode logic and the VGA output.
- All storage is synchronous to a single clock.

Parameters:
- DATA_W, 16, data RAM word width
- DATA_AW, 8, data RAM address width (depth 2^DATA_AW = 256)
- VID_W, 3, video pixel width, packed {R,G,B}
- VID_AW, 24, video address width
- VID_DEPTH, 307200, video words implemented (640*480)
- INSTR_W, 28, instruction word width

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- iInstruction  in  28  raw instruction from ROM
- iFieldEnable  in  1  load enable for the field registers
- oOperation  out  4  registered iInstruction[27:24]
- oSourceAddr0  out  8  registered iInstruction[7:0]
- oSourceAddr1  out  8  registered iInstruction[15:8]
- oDestination  out  8  registered iInstruction[23:16]
- iDataWriteEnable  in  1  data RAM write strobe
- iDataWriteAddress  in  8  data RAM write address
- iDataIn  in  16  data RAM write data
- oSourceData0  out  16  data RAM read, address iInstruction[7:0]
- oSourceData1  out  16  data RAM read, address iInstruction[15:8]
- iVideoWriteEnable  in  1  video write strobe
- iVideoWriteAddress  in  24  video write address
- iVideoDataIn  in  3  pixel write data
- iVideoReadAddress  in  24  video read address
- oVideoData  out  3  pixel read data {R,G,B}

Behaviour:
- Reset low, asynchronous: oOperation, oSourceAddr0/1, oDestination, oSourceData0/1 and oVideoData all go to 0 immediately and stay 0 while Reset is low.
- Reset does not clear RAM contents.
  - Writes are suppressed while Reset is low.
  - RAM contents are undefined after power-up until written.
- Field registers:
  - On each rising edge with iFieldEnable=1, capture the four instruction slices.
  - With iFieldEnable=0, hold their value.
  - Latency: 1 cycle.
- Data RAM reads:
  - Both ports are synchronous. On each rising edge, oSourceData0 <= mem[iInstruction[7:0]] and oSourceData1 <= mem[iInstruction[15:8]].
  - Read addresses come from the raw, unregistered instruction, so read data aligns with the field registers in the same cycle.
  - Both ports reading the same address return identical data.
- Data RAM writes: on a rising edge with iDataWriteEnable=1, mem[iDataWriteAddress] <= iDataIn.
- Read-during-write to the same address: the read returns the OLD contents; new data is visible on the next read.
- Video memory:
  - Synchronous write on a rising edge when iVideoWriteEnable=1.
  - Synchronous read: oVideoData <= vmem[iVideoReadAddress] every edge.
  - Same-address read-during-write returns old data.
- Video out-of-range handling:
  - A write with address >= VID_DEPTH is ignored.
  - A read with address >= VID_DEPTH returns 0.
- Data RAM addresses span the full depth, so no out-of-range case exists; addresses are unsigned.
- No arithmetic inside the block. Data is stored bit-exact; signedness is the consumer's concern.
- Data RAM write and video write on the same edge are independent and both take effect.

Decomposition:
- Shared package minialu_pkg holds:
  - instruction field bit positions (OP 27:24, DST 23:16, SRC1 15:8, SRC0 7:0);
  - DATA_W, DATA_AW, VID_W, VID_AW, VID_DEPTH;
  - opcode constants used by the decode logic.
- One natural sub-module: sync_ram_1w2r.
  - Parameterized width, depth and number of read ports (1 or 2).
  - Synchronous read and write, async active-low output reset, out-of-range guard.
  - Instantiated twice: data RAM with 2 read ports, video memory with 1.
- The field registers are a plain enabled register bank in the top.

Test Plan:
- Reset: drive Reset=0 mid-run with nonzero outputs -> all outputs 0 without waiting for a clock edge. Release, then read address 0x05 previously written 0x1234 -> 0x1234 (contents survive reset).
- Field capture: iInstruction=0x5A3C2B1, iFieldEnable=1 -> after one edge oOperation=0x5, oDestination=0xA3, oSourceAddr1=0xC2, oSourceAddr0=0xB1. Then change the instruction with iFieldEnable=0 -> outputs unchanged.
- Dual read: write 0x00FF to addr 3 and 0xFF00 to addr 7, then iInstruction[15:8]=7, [7:0]=3 -> next edge oSourceData1=0xFF00, oSourceData0=0x00FF. Both ports at addr 3 -> both 0x00FF.
- Read-during-write: addr 9 holds 0x0001; write 0x0002 to addr 9 while reading addr 9 -> that edge returns 0x0001, the following edge returns 0x0002.
- Video memory: write 3'b101 at 0 and 3'b010 at 307199 -> reads return 101 and 010. Write 3'b111 at 307200 -> ignored; reading 307200 returns 000.
- Concurrent writes: data write 0xBEEF to addr 0x10 and video write 3'b110 to addr 100 on the same edge -> both read back correctly.
